// File: rtl/hqa_min_search_pkg.sv
// Shared SOML decoder constants, FSM encoding and lane helper.
// Imported by the min-search slice.
package hqa_min_search_pkg;

  localparam int HQA_W     = 16;
  localparam int HQA_LANES = 4;
  localparam int HQA_NCAND = 16;
  localparam int HQA_MW    = 2*HQA_W + 1 + $clog2(4*HQA_LANES);
  localparam int HQA_IW    = $clog2(HQA_NCAND);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [HQA_W-1:0] lane_of(
    input logic [63:0] col,
    input int          k
  );
    return HQA_W'(col >> (k*HQA_W));
  endfunction

endpackage

// File: rtl/hqa_min_search_if.sv
// Candidate stream, received columns and result bundle
// of the min-search block.
interface hqa_min_search_if;
  import hqa_min_search_pkg::*;

  logic              start;
  logic [63:0]       y0_r;
  logic [63:0]       y0_i;
  logic [63:0]       y1_r;
  logic [63:0]       y1_i;
  logic [63:0]       outcol0_r;
  logic [63:0]       outcol0_i;
  logic [63:0]       outcol1_r;
  logic [63:0]       outcol1_i;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [HQA_MW-1:0] min_metric;
  logic [HQA_IW-1:0] min_idx;

  modport master (
    output start,
    output y0_r, y0_i, y1_r, y1_i,
    output outcol0_r, outcol0_i,
    output outcol1_r, outcol1_i,
    output in_valid,
    input  in_ready, busy, done,
    input  min_metric, min_idx
  );

  modport slave (
    input  start,
    input  y0_r, y0_i, y1_r, y1_i,
    input  outcol0_r, outcol0_i,
    input  outcol1_r, outcol1_i,
    input  in_valid,
    output in_ready, busy, done,
    output min_metric, min_idx
  );

endinterface

// File: rtl/hqa_min_search_lane.sv
// One lane of squared distance: stage 1 difference,
// stage 2 square.
module soml_sqdist_lane
  import hqa_min_search_pkg::*;
#(
  parameter int LW = HQA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LW-1:0]   i_y,
  input  logic [LW-1:0]   i_c,
  output logic [2*LW+1:0] o_sq
);

  logic signed [LW:0]     w_d;
  logic signed [2*LW+1:0] w_dx;
  logic signed [2*LW+1:0] w_p;
  logic signed [LW:0]     r_d;
  logic [2*LW+1:0]        r_sq;

  assign w_d  = $signed({i_y[LW-1], i_y})
              - $signed({i_c[LW-1], i_c});
  assign w_dx = (2*LW+2)'(r_d);
  assign w_p  = w_dx * w_dx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d  <= '0;
      r_sq <= '0;
    end else begin
      r_d  <= w_d;
      r_sq <= $unsigned(w_p);
    end
  end

  assign o_sq = r_sq;

endmodule

// File: rtl/hqa_min_search.sv
// Minimum squared-distance search over a stream of
// candidate columns, with a 4-stage compare pipeline.
module hqa_min_search
  import hqa_min_search_pkg::*;
#(
  parameter int W     = HQA_W,
  parameter int LANES = HQA_LANES,
  parameter int NCAND = HQA_NCAND,
  parameter int MW    = HQA_MW
) (
  input  logic      clk,
  input  logic      rst,
  hqa_min_search_if.slave bus
);

  localparam int NL = 4*LANES;
  localparam int SW = 2*W+2;
  localparam int IW = $clog2(NCAND);

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] r_i1, r_i2, r_i3;
  logic          r_v1, r_v2, r_v3;
  logic [MW-1:0] r_sum;
  logic [MW-1:0] r_min;
  logic [IW-1:0] r_min_idx;
  logic [MW-1:0] w_sum;
  logic [SW-1:0] w_sq [NL];
  logic [63:0]   w_y [4];
  logic [63:0]   w_c [4];
  logic          w_acc;
  logic          w_go;
  logic          w_last;
  logic          w_empty;

  assign w_y = '{bus.y0_r, bus.y0_i,
                 bus.y1_r, bus.y1_i};
  assign w_c = '{bus.outcol0_r, bus.outcol0_i,
                 bus.outcol1_r, bus.outcol1_i};

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      soml_sqdist_lane #(.LW(W)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .i_y  (lane_of(w_y[c], k)),
        .i_c  (lane_of(w_c[c], k)),
        .o_sq (w_sq[c*LANES+k])
      );
    end
  end

  // MW leaves log2(NL) headroom bits, so the sum never wraps
  always_comb begin
    w_sum = '0;
    for (int n = 0; n < NL; n++) begin
      w_sum = w_sum + MW'(w_sq[n]);
    end
  end

  assign w_acc   = bus.in_valid && (r_state == S_RUN);
  assign w_go    = bus.start && (r_state == S_IDLE);
  assign w_last  = (r_cnt == IW'(NCAND-1));
  assign w_empty = !(r_v1 || r_v2 || r_v3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_RUN;
      end
      S_RUN: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (w_acc && w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy = 1'b1;
        if (w_empty) w_next = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_i1  <= '0;
      r_i2  <= '0;
      r_i3  <= '0;
      r_sum <= '0;
    end else begin
      r_v1  <= w_acc;
      r_i1  <= r_cnt;
      r_v2  <= r_v1;
      r_i2  <= r_i1;
      r_v3  <= r_v2;
      r_i3  <= r_i2;
      r_sum <= w_sum;
    end
  end

  // strict compare keeps the earlier index on ties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_min     <= '0;
      r_min_idx <= '0;
    end else if (w_go) begin
      r_cnt     <= '0;
      r_min     <= '1;
      r_min_idx <= '0;
    end else begin
      if (w_acc) r_cnt <= r_cnt + 1'b1;
      if (r_v3 && (r_sum < r_min)) begin
        r_min     <= r_sum;
        r_min_idx <= r_i3;
      end
    end
  end

  assign bus.min_metric = r_min;
  assign bus.min_idx    = r_min_idx;

endmodule

// File: tb/tb_hqa_min_search.sv
// Directed bench for hqa_min_search.
// Vectors replicate one 16-bit value across all lanes.
module tb_hqa_min_search;
  import hqa_min_search_pkg::*;

  typedef logic [15:0] cv_t [16];

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  hqa_min_search_if bus ();

  hqa_min_search dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic set_y(input logic [15:0] v);
    bus.y0_r = {4{v}};
    bus.y0_i = {4{v}};
    bus.y1_r = {4{v}};
    bus.y1_i = {4{v}};
  endtask

  task automatic set_c(input logic [15:0] v);
    bus.outcol0_r = {4{v}};
    bus.outcol0_i = {4{v}};
    bus.outcol1_r = {4{v}};
    bus.outcol1_i = {4{v}};
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  // feeds candidates 0..nfeed-1, returns at negedge
  // after the last acceptance
  task automatic feed(
    input cv_t   cv,
    input int    nfeed,
    input bit    gaps,
    input bit    midstart,
    input string tag
  );
    int i;
    int cyc;
    bit ph;
    bit pulsed;
    bit acc;
    i = 0;
    cyc = 0;
    ph = 1'b1;
    pulsed = 1'b0;
    while (i < nfeed && cyc < 200) begin
      set_c(cv[i]);
      bus.in_valid = gaps ? ph : 1'b1;
      bus.start = 1'b0;
      if (midstart && i == 8 && !pulsed) begin
        bus.start = 1'b1;
        pulsed = 1'b1;
      end
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) i++;
      ph = ~ph;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    check({tag, "_fed"}, 64'(i), 64'(nfeed));
  endtask

  task automatic run_search(
    input logic [15:0] yv,
    input cv_t         cv,
    input bit          gaps,
    input bit          midstart,
    input logic [36:0] exp_m,
    input logic [3:0]  exp_i,
    input string       tag
  );
    int n;
    set_y(yv);
    do_start(tag);
    feed(cv, 16, gaps, midstart, tag);
    n = 1;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'd5);
    check({tag, "_idx"}, 64'(bus.min_idx), 64'(exp_i));
    check({tag, "_met"}, 64'(bus.min_metric),
          64'(exp_m));
    @(negedge clk);
    check({tag, "_done1"}, 64'(bus.done), 64'd0);
    check({tag, "_busy1"}, 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, 64'(bus.min_metric),
          64'(exp_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cv_t cz, ch, cx, cs;
    bit  sawd;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    set_y(16'h0);
    set_c(16'h0);
    for (int i = 0; i < 16; i++) begin
      cz[i] = 16'(i);
      ch[i] = (i == 9) ? 16'h0100 : 16'h0000;
      cx[i] = 16'h7FFF;
      cs[i] = 16'(2*i);
    end
    #3 rst = 1'b0;
    #20;
    check("rst_rdy", 64'(bus.in_ready), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_met", 64'(bus.min_metric), 64'd0);
    check("rst_idx", 64'(bus.min_idx), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // idle in_valid must be ignored
    bus.in_valid = 1'b1;
    set_c(16'h1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_done", 64'(bus.done), 64'd0);
    end
    bus.in_valid = 1'b0;
    check("idle_met", 64'(bus.min_metric), 64'd0);

    run_search(16'h0000, cz, 1'b0, 1'b0,
               37'd0, 4'd0, "zero");
    run_search(16'h0100, ch, 1'b0, 1'b0,
               37'd0, 4'd9, "hit");
    run_search(16'h8000, cx, 1'b0, 1'b0,
               37'h0FFFE00010, 4'd0, "ext");
    // y=5, cand=2i: |d|=1 at i=2 and i=3, tie -> 2
    run_search(16'h0005, cs, 1'b0, 1'b0,
               37'd16, 4'd2, "tie");
    run_search(16'h0005, cs, 1'b1, 1'b1,
               37'd16, 4'd2, "stall");

    // reset after 7th candidate
    set_y(16'h0100);
    do_start("mrst");
    feed(ch, 7, 1'b0, 1'b0, "mrst");
    rst = 1'b0;
    #1;
    check("mrst_rdy", 64'(bus.in_ready), 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_done", 64'(bus.done), 64'd0);
    check("mrst_met", 64'(bus.min_metric), 64'd0);
    check("mrst_idx", 64'(bus.min_idx), 64'd0);
    sawd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) sawd = 1'b1;
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) sawd = 1'b1;
    end
    check("mrst_nodone", 64'(sawd), 64'd0);
    run_search(16'h0100, ch, 1'b0, 1'b0,
               37'd0, 4'd9, "rerun");

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hqa_min_search.md
HQA_MIN_SEARCH -- requirements
Module: hqa_min_search

Interface
REQ-001 SHALL have parameter W, default 16: signed width of one lane.
REQ-002 SHALL have parameter LANES, default 4: lanes per 64-bit column word, with lane k at bits [W*k+W-1 : W*k].
REQ-003 SHALL have parameter NCAND, default 16: number of candidates searched per run.
REQ-004 SHALL have parameter MW, default 37 (2W+1+log2(4*LANES)): width of the metric.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a search run.
REQ-008 y0_r, y0_i, y1_r, y1_i  input  64 each  received columns, held stable for the whole run.
REQ-009 outcol0_r, outcol0_i, outcol1_r, outcol1_i  input  64 each  candidate columns from HqA1_cal.
REQ-010 in_valid  input  1  candidate columns valid; driven by HqA1_cal ready.
REQ-011 in_ready  output  1  block accepts a candidate this cycle.
REQ-012 busy  output  1  a run is in progress.
REQ-013 done  output  1  one-cycle pulse; results are valid.
REQ-014 min_metric  output  MW  smallest metric of the run.
REQ-015 min_idx  output  clog2(NCAND)  index of the candidate with the smallest metric.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE -> RUN SHALL occur on start=1; entering RUN SHALL clear the candidate counter and load the running minimum with all-ones.
REQ-018 in_ready SHALL be 1 only in RUN.
REQ-019 A candidate SHALL be accepted only when in_valid=1 and in_ready=1; its index SHALL be the counter value, and the counter SHALL increment on acceptance.
REQ-020 RUN -> DRAIN SHALL occur on acceptance of candidate NCAND-1.
REQ-021 DRAIN -> DONE SHALL occur once the pipeline holds no valid data.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 Pipeline stage 1 SHALL compute per-lane differences d = y - outcol, sign-extended to W+1 bits, for all 4*LANES real and imaginary lanes.
REQ-024 Stage 2 SHALL compute the squares d*d as unsigned 2W+2-bit values.
REQ-025 Stage 3 SHALL sum all 4*LANES squares into an MW-bit metric without overflow or saturation.
REQ-026 Stage 4 SHALL update the running minimum and its index when metric < running minimum (strict); on a tie the lower index SHALL be kept.
REQ-027 Latency from acceptance to the minimum update SHALL be 4 cycles; each stage SHALL carry a valid bit and its candidate index.
REQ-028 done SHALL assert 5 cycles after acceptance of the last candidate.
REQ-029 min_metric and min_idx SHALL hold their values from DONE until the next start.
REQ-030 in_valid while not in RUN SHALL be ignored; it SHALL not advance the counter or inject pipeline data.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-033 Gaps in in_valid during RUN SHALL stall only the counter, with no effect on results.

Reset
REQ-034 rst=0 SHALL asynchronously force state IDLE, counter 0, all pipeline valid bits 0, in_ready=0, busy=0, done=0, min_metric=0 and min_idx=0.
REQ-035 Reset mid-run SHALL abandon the run with no done pulse; a new start after reset release SHALL run normally.

Structure
REQ-036 The shared SOML decoder package SHALL hold W, LANES, NCAND, MW, the FSM state encoding, and a lane-extract function.
REQ-037 One sub-module, soml_sqdist_lane, SHALL implement the difference and square for one lane and be instantiated 4*LANES times.
REQ-038 Accumulation, compare and FSM SHALL reside in hqa_min_search.

Verification
REQ-039 Zero match: y = 0 for all lanes; candidates i=0..15 have every lane = i. Expect done with min_idx=0 and min_metric=0.
REQ-040 Exact hit: y has every lane = 0x0100; candidate 9 equals y and all others have every lane = 0x0000. Expect min_idx=9 and min_metric=0.
REQ-041 Tie and extremes: every candidate has every lane = 0x7FFF and y has every lane = 0x8000. Expect min_idx=0 and min_metric=16*65535^2=0x0FFFE00010, with no overflow.
REQ-042 Stalls and ignored inputs: in_valid toggles every other cycle and start is pulsed mid-run. Expect the same result as a gap-free run, and done exactly 5 cycles after the 16th acceptance.
REQ-043 Mid-run reset: rst=0 after the 7th candidate. Expect all outputs 0 and no done pulse; a rerun after reset release gives the correct result.
REQ-044 Idle input: in_valid=1 in IDLE for 10 cycles. Expect busy=0, done=0 and the counter unchanged.
